// File: rtl/bus_response_mux.sv
// bus_response_mux
//   Return path from the decoded responders back to the CPU load/store unit.
//   The select vector is latched when a request is accepted. Only the chosen
//   responder's ready/data are observed from then on. A single-cycle
//   acknowledge is returned, qualified by a bus-error flag.
//
//   An access becomes a bus error, with Data_Out_H = ERR_DATA, when:
//     - no select is high (unmapped),
//     - more than one select is high (decoder overlap), or
//     - the selected responder stays not-ready for TIMEOUT_CYCLES wait cycles.
//
//   Optional error logging is enabled with the macro BUS_ERR_LOG_EN. When it
//   is defined, Err_Address and Err_Count record the failed accesses. When it
//   is undefined, both outputs are tied to zero.
//
// Ports
//   Clock, Reset_L       rising-edge clock, asynchronous active-low reset
//   Req_H, Address       master request (held until Ack_H) and its address
//   *_Select_H           one-hot selects from the address decoder
//   *_Ready_H, *_Data    responder ready strobes and read data
//   Data_Out_H           registered read data, held until the next response
//   Ack_H, Bus_Error_H   one-cycle completion pulse and its error qualifier
//   Err_Address          address of the most recent failed access
//   Err_Count            saturating count of failed accesses
module bus_response_mux #(
  parameter int                 DATA_W         = 32,
  parameter int                 TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0]  ERR_DATA       = DATA_W'(32'hDEADBEEF)
) (
  input  logic              Clock,
  input  logic              Reset_L,
  input  logic              Req_H,
  input  logic [31:0]       Address,
  input  logic              ROM_Select_H,
  input  logic              RAM_Select_H,
  input  logic              IO_Select_H,
  input  logic              Graphics_Select_H,
  input  logic              Keyboard_Select_H,
  input  logic              UART_Select_H,
  input  logic              ROM_Ready_H,
  input  logic              RAM_Ready_H,
  input  logic              IO_Ready_H,
  input  logic              Graphics_Ready_H,
  input  logic              Keyboard_Ready_H,
  input  logic              UART_Ready_H,
  input  logic [DATA_W-1:0] ROM_Data,
  input  logic [DATA_W-1:0] RAM_Data,
  input  logic [DATA_W-1:0] IO_Data,
  input  logic [DATA_W-1:0] Graphics_Data,
  input  logic [DATA_W-1:0] Keyboard_Data,
  input  logic [DATA_W-1:0] UART_Data,
  output logic [DATA_W-1:0] Data_Out_H,
  output logic              Ack_H,
  output logic              Bus_Error_H,
  output logic [31:0]       Err_Address,
  output logic [7:0]        Err_Count
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [5:0]          sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ack_q, ack_d;
  logic                berr_q, berr_d;

  logic [5:0]          live_sel;
  logic [5:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_data [6];
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_data;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
  function automatic logic is_one_hot(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  // Bit order is shared by the selects, the readies and the data array.
  assign live_sel  = {UART_Select_H, Keyboard_Select_H, Graphics_Select_H,
                      IO_Select_H, RAM_Select_H, ROM_Select_H};
  assign rsp_ready = {UART_Ready_H, Keyboard_Ready_H, Graphics_Ready_H,
                      IO_Ready_H, RAM_Ready_H, ROM_Ready_H};
  assign rsp_data[0] = ROM_Data;
  assign rsp_data[1] = RAM_Data;
  assign rsp_data[2] = IO_Data;
  assign rsp_data[3] = Graphics_Data;
  assign rsp_data[4] = Keyboard_Data;
  assign rsp_data[5] = UART_Data;

  // The latched select is one-hot whenever it is used in WAIT, so an AND-OR
  // mux is sufficient. Responders that are not selected are masked to zero.
  assign sel_ready = |(sel_q & rsp_ready);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < 6; i++) begin
      if (sel_q[i]) sel_data = sel_data | rsp_data[i];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req_H) begin
          sel_d = live_sel;
          cnt_d = '0;
          if (is_one_hot(live_sel)) begin
            err_d   = 1'b0;
            state_d = S_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        // Ready takes priority over the timeout, even on the last count.
        if (sel_ready) begin
          data_d  = sel_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        ack_d   = 1'b1;
        berr_d  = err_q;
        if (err_q) data_d = ERR_DATA;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered response: Ack_H, Bus_Error_H and Data_Out_H leave RESP together.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      berr_q  <= berr_d;
    end
  end

  assign Data_Out_H  = data_q;
  assign Ack_H       = ack_q;
  assign Bus_Error_H = berr_q;

`ifdef BUS_ERR_LOG_EN
  logic [31:0] addr_q;
  logic [31:0] err_addr_q;
  logic [7:0]  err_cnt_q;

  // Error log is updated on the same edge that raises Ack_H.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      addr_q     <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (state_q == S_IDLE && Req_H) addr_q <= Address;
      if (state_q == S_RESP && err_q) begin
        err_addr_q <= addr_q;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign Err_Address = err_addr_q;
  assign Err_Count   = err_cnt_q;
`else
  // Without logging the address is not needed. It is reduced into a net whose
  // name marks it as deliberately unused.
  logic unused_address;
  assign unused_address = ^Address;

  assign Err_Address = '0;
  assign Err_Count   = '0;
`endif

endmodule

// File: tb/tb_bus_response_mux.sv
module tb_bus_response_mux;
  localparam int DATA_W = 32;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  logic              Clock = 1'b0;
  logic              Reset_L;
  logic              Req_H;
  logic [31:0]       Address;
  logic [5:0]        sel_v;
  logic [5:0]        rdy_v;
  logic [5:0]        rdy_base;
  logic [DATA_W-1:0] data_v [6];
  logic [DATA_W-1:0] Data_Out_H;
  logic              Ack_H;
  logic              Bus_Error_H;
  logic [31:0]       Err_Address;
  logic [7:0]        Err_Count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  bus_response_mux #(
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(16),
    .ERR_DATA(ERR_WORD)
  ) dut (
    .Clock(Clock),
    .Reset_L(Reset_L),
    .Req_H(Req_H),
    .Address(Address),
    .ROM_Select_H(sel_v[0]),
    .RAM_Select_H(sel_v[1]),
    .IO_Select_H(sel_v[2]),
    .Graphics_Select_H(sel_v[3]),
    .Keyboard_Select_H(sel_v[4]),
    .UART_Select_H(sel_v[5]),
    .ROM_Ready_H(rdy_v[0]),
    .RAM_Ready_H(rdy_v[1]),
    .IO_Ready_H(rdy_v[2]),
    .Graphics_Ready_H(rdy_v[3]),
    .Keyboard_Ready_H(rdy_v[4]),
    .UART_Ready_H(rdy_v[5]),
    .ROM_Data(data_v[0]),
    .RAM_Data(data_v[1]),
    .IO_Data(data_v[2]),
    .Graphics_Data(data_v[3]),
    .Keyboard_Data(data_v[4]),
    .UART_Data(data_v[5]),
    .Data_Out_H(Data_Out_H),
    .Ack_H(Ack_H),
    .Bus_Error_H(Bus_Error_H),
    .Err_Address(Err_Address),
    .Err_Count(Err_Count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Runs one access. The task is entered 1 time unit after a rising edge.
  // rdy_mask is raised after edge N+rdy_at (-1 means never), where edge N
  // samples the request. The latency counts edges from N until Ack_H is high.
  task automatic access(input string tag, input logic [5:0] sel, input logic [31:0] addr,
                        input logic [5:0] rdy_mask, input int rdy_at, input int exp_lat,
                        input logic [31:0] exp_data, input logic exp_err);
    int lat;
    bit got;
    sel_v   = sel;
    Address = addr;
    rdy_v   = rdy_base;
    Req_H   = 1'b1;
    tick();
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      if (lat == rdy_at) rdy_v = rdy_base | rdy_mask;
      tick();
      lat++;
      if (Ack_H) got = 1;
    end
    Req_H = 1'b0;
    sel_v = '0;
    rdy_v = rdy_base;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, Data_Out_H, exp_data);
    check({tag, " bus_error"}, Bus_Error_H, exp_err);
    tick();
    check({tag, " ack one cycle"}, Ack_H, 1'b0);
  endtask

  initial begin
    int lat;
    int acks;
    Reset_L  = 1'b0;
    Req_H    = 1'b0;
    Address  = '0;
    sel_v    = '0;
    rdy_v    = '0;
    rdy_base = '0;
    for (int i = 0; i < 6; i++) data_v[i] = '0;

    tick();
    check("reset data", Data_Out_H, 32'h0);
    check("reset ack", Ack_H, 1'b0);
    check("reset bus_error", Bus_Error_H, 1'b0);
    check("reset err_addr", Err_Address, 32'h0);
    check("reset err_cnt", Err_Count, 8'h0);
    tick();
    Reset_L = 1'b1;
    tick();

    data_v[1] = 32'h12345678;
    access("ram", 6'b000010, 32'h0000_1000, 6'b000010, 0, 2, 32'h12345678, 1'b0);

    data_v[5] = 32'h000000A5;
    access("uart", 6'b100000, 32'h0000_2000, 6'b100000, 5, 7, 32'h000000A5, 1'b0);
    tick();
    tick();
    check("data hold", Data_Out_H, 32'h000000A5);

    access("unmapped", 6'b000000, 32'h0200_0000, 6'b000000, -1, 1, ERR_WORD, 1'b1);
`ifdef BUS_ERR_LOG_EN
    check("unmapped err_addr", Err_Address, 32'h0200_0000);
    check("unmapped err_cnt", Err_Count, 8'd1);
`else
    check("unmapped err_addr", Err_Address, 32'h0);
    check("unmapped err_cnt", Err_Count, 8'd0);
`endif

    data_v[2] = 32'h00001010;
    access("timeout", 6'b000100, 32'h0000_3000, 6'b000100, -1, 17, ERR_WORD, 1'b1);
    access("ready at limit", 6'b000100, 32'h0000_3004, 6'b000100, 15, 17, 32'h00001010, 1'b0);

    access("overlap", 6'b000011, 32'h0000_4000, 6'b000011, 0, 1, ERR_WORD, 1'b1);
`ifdef BUS_ERR_LOG_EN
    check("overlap err_addr", Err_Address, 32'h0000_4000);
    check("overlap err_cnt", Err_Count, 8'd3);
`endif

    // Graphics is always ready with all-ones data, but Keyboard is selected.
    rdy_base  = 6'b001000;
    data_v[3] = 32'hFFFFFFFF;
    data_v[4] = 32'h0000004B;
    access("kbd no ready", 6'b010000, 32'h0000_5000, 6'b000000, -1, 17, ERR_WORD, 1'b1);
    access("kbd", 6'b010000, 32'h0000_5004, 6'b010000, 2, 4, 32'h0000004B, 1'b0);
    rdy_base = '0;
    rdy_v    = '0;

    // Reset in the middle of a RAM wait.
    sel_v   = 6'b000010;
    Address = 32'h0000_1008;
    Req_H   = 1'b1;
    tick();
    tick();
    tick();
    #2;
    Reset_L = 1'b0;
    Req_H   = 1'b0;
    sel_v   = '0;
    #1;
    check("async reset data", Data_Out_H, 32'h0);
    check("async reset ack", Ack_H, 1'b0);
    check("async reset bus_error", Bus_Error_H, 1'b0);
    check("async reset err_cnt", Err_Count, 8'h0);
    check("async reset err_addr", Err_Address, 32'h0);
    rdy_v = 6'b000010;
    tick();
    tick();
    Reset_L = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Ack_H) acks++;
    end
    check("no ack after reset", acks, 0);

    // Two RAM reads back to back, with Req_H held high through the first Ack_H.
    sel_v     = 6'b000010;
    rdy_v     = 6'b000010;
    data_v[1] = 32'h11111111;
    Address   = 32'h0000_1100;
    Req_H     = 1'b1;
    tick();
    lat = 0;
    while (!Ack_H && lat < 40) begin
      tick();
      lat++;
    end
    check("b2b first latency", lat, 2);
    check("b2b first data", Data_Out_H, 32'h11111111);
    data_v[1] = 32'h22222222;
    Address   = 32'h0000_1104;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!Ack_H && lat < 40);
    check("b2b second latency", lat, 3);
    check("b2b second data", Data_Out_H, 32'h22222222);
    check("b2b second bus_error", Bus_Error_H, 1'b0);
    Req_H = 1'b0;
    sel_v = '0;
    rdy_v = '0;
    tick();
    check("b2b ack one cycle", Ack_H, 1'b0);

`ifdef BUS_ERR_LOG_EN
    for (int i = 0; i < 260; i++) begin
      access("sat", 6'b000000, 32'h0300_0000 + i, 6'b000000, -1, 1, ERR_WORD, 1'b1);
    end
    check("err_cnt saturate", Err_Count, 8'hFF);
    check("err_addr last", Err_Address, 32'h0300_0103);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
